mem_access_unit: RTL and testbench

- Memory stage directly downstream of the load/store buffer.
- Accepts at most one issued lw/sw per cycle (valid, ROBEN, Rd, opcode, EA, store data) and performs the word access on a private data RAM.
- Broadcasts the completion (load value or store-done) on the CDB after a fixed pipeline latency.
- Supports ROB flush and flags misaligned or out-of-range addresses.

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_word_ram.sv | 29 ++
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared widths, opcode constants and the CDB payload type for the memory stage.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ROBEN_W = 5;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned OPC_W   = 12;

  localparam logic [OPC_W-1:0] OPC_LW = 12'h023;
  localparam logic [OPC_W-1:0] OPC_SW = 12'h02B;

  typedef struct packed {
    logic               valid;
    logic [ROBEN_W-1:0] roben;
    logic [RD_W-1:0]    rd;
    logic [DATA_W-1:0]  result;
    logic               store_done;
    logic               exception;
  } cdb_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word RAM: falling-edge write, combinational read, plus a debug read port.
module mem_word_ram
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: performs lw/sw on a private RAM and broadcasts completion on the CDB
// after a fixed LATENCY, with flush and address-fault handling.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_VALID_Inst,
  input  logic [ROBEN_W-1:0]   in_ROBEN,
  input  logic [RD_W-1:0]      in_Rd,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [DATA_W-1:0]    in_EA,
  input  logic [DATA_W-1:0]    in_Store_Data,
  input  logic                 ROB_FLUSH_Flag,
  output logic                 out_VALID,
  output logic [ROBEN_W-1:0]   out_ROBEN,
  output logic [RD_W-1:0]      out_Rd,
  output logic [DATA_W-1:0]    out_Result,
  output logic                 out_Store_Done,
  output logic                 out_Exception,
  output logic                 busy_test,
  input  logic [ADDR_BITS-1:0] mem_index_test,
  output logic [DATA_W-1:0]    mem_word_test
);

  localparam int unsigned LAST = LATENCY - 1;

  logic                 is_sw;
  logic                 accept;
  logic                 fault;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] word_idx;
  logic [DATA_W-1:0]    ram_rdata;
  cdb_t                 new_entry;
  cdb_t                 stage_in [LATENCY];
  cdb_t                 pipe     [LATENCY];

  assign is_sw    = (in_opcode == OPC_SW);
  assign accept   = in_VALID_Inst && (in_ROBEN != '0) && !ROB_FLUSH_Flag && is_mem_op(in_opcode);
  assign fault    = (|in_EA[1:0]) || (|in_EA[DATA_W-1:ADDR_BITS+2]);
  assign ram_we   = accept && is_sw && !fault;
  assign word_idx = in_EA[ADDR_BITS+1:2];

  mem_word_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk      (clk),
    .we       (ram_we),
    .addr     (word_idx),
    .wdata    (in_Store_Data),
    .rdata    (ram_rdata),
    .dbg_addr (mem_index_test),
    .dbg_data (mem_word_test)
  );

  // Stage-0 payload: stores and faults broadcast a zero result.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = accept;
    new_entry.roben      = in_ROBEN;
    new_entry.rd         = in_Rd;
    new_entry.result     = (is_sw || fault) ? '0 : ram_rdata;
    new_entry.store_done = is_sw;
    new_entry.exception  = fault;
  end

  always_comb begin
    stage_in    = '{default: '0};
    stage_in[0] = new_entry;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_in[i] = pipe[i-1];
    end
  end

  // Last stage doubles as the CDB output register; payload holds while it is empty.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (ROB_FLUSH_Flag) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i].valid <= 1'b0;
      end
      pipe[LAST].roben <= '0;
    end else begin
      for (int unsigned i = 0; i < LAST; i++) begin
        pipe[i] <= stage_in[i];
      end
      if (stage_in[LAST].valid) begin
        pipe[LAST] <= stage_in[LAST];
      end else begin
        pipe[LAST].valid <= 1'b0;
        pipe[LAST].roben <= '0;
      end
    end
  end

  always_comb begin
    busy_test = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      busy_test = busy_test | pipe[i].valid;
    end
  end

  assign out_VALID      = pipe[LAST].valid;
  assign out_ROBEN      = pipe[LAST].roben;
  assign out_Rd         = pipe[LAST].rd;
  assign out_Result     = pipe[LAST].result;
  assign out_Store_Done = pipe[LAST].store_done;
  assign out_Exception  = pipe[LAST].exception;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ADDR_BITS=10, LATENCY=2); DUT acts on falling edges.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_VALID_Inst;
  logic [4:0]  in_ROBEN;
  logic [4:0]  in_Rd;
  logic [11:0] in_opcode;
  logic [31:0] in_EA;
  logic [31:0] in_Store_Data;
  logic        ROB_FLUSH_Flag;
  logic        out_VALID;
  logic [4:0]  out_ROBEN;
  logic [4:0]  out_Rd;
  logic [31:0] out_Result;
  logic        out_Store_Done;
  logic        out_Exception;
  logic        busy_test;
  logic [9:0]  mem_index_test;
  logic [31:0] mem_word_test;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_BITS(10), .LATENCY(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_VALID_Inst  (in_VALID_Inst),
    .in_ROBEN       (in_ROBEN),
    .in_Rd          (in_Rd),
    .in_opcode      (in_opcode),
    .in_EA          (in_EA),
    .in_Store_Data  (in_Store_Data),
    .ROB_FLUSH_Flag (ROB_FLUSH_Flag),
    .out_VALID      (out_VALID),
    .out_ROBEN      (out_ROBEN),
    .out_Rd         (out_Rd),
    .out_Result     (out_Result),
    .out_Store_Done (out_Store_Done),
    .out_Exception  (out_Exception),
    .busy_test      (busy_test),
    .mem_index_test (mem_index_test),
    .mem_word_test  (mem_word_test)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] roben, input logic [4:0] rd, input logic [11:0] opc,
                         input logic [31:0] ea, input logic [31:0] data);
    in_VALID_Inst = 1'b1;
    in_ROBEN      = roben;
    in_Rd         = rd;
    in_opcode     = opc;
    in_EA         = ea;
    in_Store_Data = data;
  endtask

  task automatic idle_req();
    in_VALID_Inst = 1'b0;
    in_ROBEN      = '0;
    in_Rd         = '0;
    in_opcode     = '0;
    in_EA         = '0;
    in_Store_Data = '0;
  endtask

  // One active (falling) edge, then return at the next rising edge for sampling.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check_ram(input string tag, input logic [9:0] idx, input logic [31:0] exp);
    mem_index_test = idx;
    #1;
    check(tag, mem_word_test, exp);
  endtask

  logic [4:0]  exp_rob [3] = '{5'd1, 5'd2, 5'd5};
  logic [31:0] exp_val [3] = '{32'h11, 32'h22, 32'h55};
  logic [31:0] pre_ea  [5] = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h20};
  logic [31:0] pre_val [5] = '{32'hA0A0A0A0, 32'h11, 32'h22, 32'h55, 32'h88888888};

  initial begin
    rst            = 1'b0;
    ROB_FLUSH_Flag = 1'b0;
    mem_index_test = '0;
    idle_req();
    tick();
    tick();

    check("reset_valid",  32'(out_VALID), 32'd0);
    check("reset_roben",  32'(out_ROBEN), 32'd0);
    check("reset_result", out_Result, 32'd0);
    check("reset_busy",   32'(busy_test), 32'd0);
    rst = 1'b1;
    tick();

    // Preload through ordinary stores.
    for (int i = 0; i < 5; i++) begin
      set_req(5'd31, 5'd0, OPC_SW, pre_ea[i], pre_val[i]);
      tick();
    end
    idle_req();
    tick();
    tick();
    check("preload_idle_valid", 32'(out_VALID), 32'd0);

    // Store then load to the same word.
    set_req(5'd3, 5'd0, OPC_SW, 32'h10, 32'hDEADBEEF);
    tick();
    check("st_not_yet", 32'(out_VALID), 32'd0);
    set_req(5'd4, 5'd7, OPC_LW, 32'h10, 32'h0);
    tick();
    idle_req();
    check("st_valid",  32'(out_VALID), 32'd1);
    check("st_roben",  32'(out_ROBEN), 32'd3);
    check("st_done",   32'(out_Store_Done), 32'd1);
    check("st_result", out_Result, 32'd0);
    check("st_exc",    32'(out_Exception), 32'd0);
    tick();
    check("ld_valid",  32'(out_VALID), 32'd1);
    check("ld_roben",  32'(out_ROBEN), 32'd4);
    check("ld_rd",     32'(out_Rd), 32'd7);
    check("ld_result", out_Result, 32'hDEADBEEF);
    check("ld_done",   32'(out_Store_Done), 32'd0);
    check_ram("ram4_after_st", 10'd4, 32'hDEADBEEF);
    tick();
    check("st_ld_drain", 32'(out_VALID), 32'd0);

    // Back-to-back loads.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_req(exp_rob[i], 5'(i + 10), OPC_LW, pre_ea[i + 1], 32'h0);
      else idle_req();
      tick();
      if (i >= 1 && i <= 3) begin
        check($sformatf("b2b_valid%0d", i - 1), 32'(out_VALID), 32'd1);
        check($sformatf("b2b_roben%0d", i - 1), 32'(out_ROBEN), 32'(exp_rob[i - 1]));
        check($sformatf("b2b_rd%0d", i - 1),    32'(out_Rd), 32'(i + 9));
        check($sformatf("b2b_res%0d", i - 1),   out_Result, exp_val[i - 1]);
      end
    end
    check("b2b_after_valid", 32'(out_VALID), 32'd0);
    check("b2b_after_roben", 32'(out_ROBEN), 32'd0);
    check("b2b_hold_result", out_Result, 32'h55);

    // Misaligned store.
    set_req(5'd9, 5'd0, OPC_SW, 32'h13, 32'h12345678);
    tick();
    idle_req();
    tick();
    check("mis_valid", 32'(out_VALID), 32'd1);
    check("mis_roben", 32'(out_ROBEN), 32'd9);
    check("mis_exc",   32'(out_Exception), 32'd1);
    check("mis_res",   out_Result, 32'd0);
    check_ram("mis_ram4", 10'd4, 32'hDEADBEEF);

    // Out-of-range load.
    set_req(5'd10, 5'd3, OPC_LW, 32'h0000_1000, 32'h0);
    tick();
    idle_req();
    tick();
    check("oor_valid", 32'(out_VALID), 32'd1);
    check("oor_roben", 32'(out_ROBEN), 32'd10);
    check("oor_exc",   32'(out_Exception), 32'd1);
    check("oor_res",   out_Result, 32'd0);
    tick();

    // Flush squashes an in-flight load and a concurrent store.
    set_req(5'd6, 5'd1, OPC_LW, 32'h04, 32'h0);
    tick();
    set_req(5'd7, 5'd0, OPC_SW, 32'h20, 32'h1);
    ROB_FLUSH_Flag = 1'b1;
    tick();
    ROB_FLUSH_Flag = 1'b0;
    idle_req();
    check("flush_valid0", 32'(out_VALID), 32'd0);
    check("flush_busy",   32'(busy_test), 32'd0);
    tick();
    check("flush_valid1", 32'(out_VALID), 32'd0);
    check_ram("flush_ram8", 10'd8, 32'h88888888);

    // Reset while requests are in flight.
    set_req(5'd12, 5'd2, OPC_LW, 32'h08, 32'h0);
    tick();
    set_req(5'd13, 5'd4, OPC_LW, 32'h14, 32'h0);
    tick();
    idle_req();
    check("pre_rst_roben", 32'(out_ROBEN), 32'd12);
    rst = 1'b0;
    #1;
    check("rst_valid",  32'(out_VALID), 32'd0);
    check("rst_roben",  32'(out_ROBEN), 32'd0);
    check("rst_rd",     32'(out_Rd), 32'd0);
    check("rst_result", out_Result, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst_no_bcast", 32'(out_VALID), 32'd0);
    check_ram("rst_ram2", 10'd2, 32'h22);
    check_ram("rst_ram4", 10'd4, 32'hDEADBEEF);

    // ROBEN=0 and illegal opcode are dropped without a RAM write.
    set_req(5'd0, 5'd0, OPC_SW, 32'h0, 32'h5);
    tick();
    set_req(5'd14, 5'd0, 12'hFFF, 32'h0, 32'h7);
    tick();
    idle_req();
    check("rob0_valid", 32'(out_VALID), 32'd0);
    tick();
    check("illop_valid", 32'(out_VALID), 32'd0);
    check_ram("rob0_ram0", 10'd0, 32'hA0A0A0A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
